pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit. Drives the stall and flush inputs of every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).
//  Arbitrates stage stall requests, EX branch redirects and trap redirects. Holds a redirect that arrives during a
//  memory stall until the stall clears, and stretches the if_id flush to cover the fetch latency. Sits beside the core datapath.
// PARAMETERS
//  FLUSH_CYCLES  2     cycles flush_if_id_o stays high per redirect (fetch latency, 1..15)
//  WDT_LIMIT     1024  consecutive stalled cycles before stall_timeout_o (watchdog build only)
// PORTS
//  clk               in   1   core clock, rising edge
//  rst_n             in   1   asynchronous active-low reset
//  stallreq_if_i     in   1   fetch not ready
//  stallreq_id_i     in   1   load-use hazard in ID
//  stallreq_ex_i     in   1   multi-cycle EX op busy (div)
//  stallreq_mem_i    in   1   data bus wait
//  ex_branch_flag_i  in   1   EX resolved taken branch/jump
//  ex_branch_addr_i  in   32  branch target
//  trap_req_i        in   1   exception/interrupt accepted
//  trap_addr_i       in   32  trap vector
//  stall_o           out  5   {mem_wb,ex_mem,id_ex,if_id,pc}; bit=1 holds that register
//  flush_if_id_o     out  1   zero if_id
//  flush_id_ex_o     out  1   zero id_ex (bubble)
//  redirect_o        out  1   load pc from redirect_pc_o this cycle
//  redirect_pc_o     out  32  redirect target
//  stall_timeout_o   out  1   watchdog pulse (0 when feature compiled out)
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, flush counter 0, pending target 0, watchdog counter 0.
//  stall_o is combinational, highest request wins: mem->5'b01111, ex->5'b00111, id->5'b00011, if->5'b00001, none->0.
//  id stall also asserts flush_id_ex_o (bubble into EX) unless ex/mem stall is active.
//  States: RUN, PEND, FLUSH.
//  RUN: trap_req_i or ex_branch_flag_i -> trap wins (target=trap_addr_i, else ex_branch_addr_i).
//   - stallreq_mem_i=0: same cycle redirect_o=1, redirect_pc_o=target, flush_if_id_o=flush_id_ex_o=1, stall_o=0
//     (redirect overrides ex/id/if stalls); FLUSH_CYCLES>1 -> FLUSH with cnt=FLUSH_CYCLES-1, else stay RUN.
//   - stallreq_mem_i=1: no redirect; latch target into pend_pc, -> PEND.
//  PEND: stall_o per requests, redirect_o=0. First cycle stallreq_mem_i=0: redirect_o=1, redirect_pc_o=pend_pc,
//   both flushes=1 -> FLUSH/RUN as above. New trap_req_i while in PEND overwrites pend_pc (trap>branch); branch ignored.
//  FLUSH: flush_if_id_o=1; cnt decrements each cycle stall_o[0]=0; cnt reaching 0 -> RUN after that cycle.
//   New redirect in FLUSH follows the RUN rules and reloads cnt (or moves to PEND if mem stalled).
//  Redirect and its flushes are single-cycle pulses. pend_pc is registered; everything else is comb from state+inputs.
//  Reset mid-PEND/FLUSH: pending redirect dropped, state RUN.
// CONFIGURATION
//  PIPE_CTRL_WDT_EN defined: 16-bit counter increments each cycle stall_o!=0 and clears when stall_o==0 or on redirect.
//   When it reaches WDT_LIMIT: stall_timeout_o=1 for one cycle, counter clears.
//  Undefined: no counter, stall_timeout_o tied 0.
// TESTING
//  1 stallreq_id_i=1 one cycle -> stall_o=5'b00011, flush_id_ex_o=1; next cycle stall_o=0.
//  2 stallreq_mem_i=1 with stallreq_ex_i=1 -> stall_o=5'b01111, flush_id_ex_o=0.
//  3 ex_branch_flag_i=1, addr=0x80000040, no stall -> same cycle redirect_o=1, pc=0x80000040, both flushes=1;
//    flush_if_id_o stays 1 for the next cycle (FLUSH_CYCLES=2), then 0.
//  4 branch 0x100 and trap 0x200 in the same cycle -> redirect_pc_o=0x200.
//  5 branch 0x300 during a 3-cycle mem stall -> redirect_o=0 for 3 cycles; redirect 0x300 on the first unstalled cycle.
//  6 WDT_LIMIT=8, build with PIPE_CTRL_WDT_EN, stallreq_ex_i held -> stall_timeout_o pulses on the 8th stalled cycle;
//    rst_n low mid-FLUSH -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush arbitration, branch/trap redirect with hold-over across memory stalls.
// Optional watchdog on long stalls is built when PIPE_CTRL_WDT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WDT_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_addr_i,
  output logic [4:0]  stall_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        stall_timeout_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("FLUSH_CYCLES must be 1..15");
  end
  if (WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_wdt
    $error("WDT_LIMIT must be 1..65535");
  end

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic [4:0]  stall_req;
  logic        redir;
  logic [31:0] redir_pc;

  // Highest stalled stage freezes itself and everything upstream.
  always_comb begin
    if      (stallreq_mem_i) stall_req = 5'b01111;
    else if (stallreq_ex_i)  stall_req = 5'b00111;
    else if (stallreq_id_i)  stall_req = 5'b00011;
    else if (stallreq_if_i)  stall_req = 5'b00001;
    else                     stall_req = 5'b00000;
  end

  // A redirect can only be issued while the memory stage is free; a trap always wins the target.
  always_comb begin
    redir    = 1'b0;
    redir_pc = 32'h0;
    if (!stallreq_mem_i) begin
      if (state_q == PEND) begin
        redir    = 1'b1;
        redir_pc = trap_req_i ? trap_addr_i : pend_q;
      end else if (trap_req_i || ex_branch_flag_i) begin
        redir    = 1'b1;
        redir_pc = trap_req_i ? trap_addr_i : ex_branch_addr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (redir) begin
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_d   = FLUSH_RELOAD;
    end else if (state_q == PEND) begin
      if (trap_req_i) pend_d = trap_addr_i;
    end else if (trap_req_i || ex_branch_flag_i) begin
      state_d = PEND;
      cnt_d   = 4'd0;
      pend_d  = trap_req_i ? trap_addr_i : ex_branch_addr_i;
    end else if (state_q == FLUSH && !stall_req[0]) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = RUN;
    end
  end

  // Outputs are forced low while reset is asserted so the pipeline sees no stale control.
  always_comb begin
    stall_o       = 5'b00000;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0;
    if (rst_n) begin
      stall_o       = redir ? 5'b00000 : stall_req;
      flush_if_id_o = redir || (state_q == FLUSH);
      flush_id_ex_o = redir || (stall_req == 5'b00011);
      redirect_o    = redir;
      redirect_pc_o = redir_pc;
    end
  end

`ifdef PIPE_CTRL_WDT_EN
  logic [15:0] wdt_q, wdt_d;
  logic        wdt_hit;

  always_comb begin
    wdt_hit = (stall_o != 5'b00000) && (wdt_q == 16'(WDT_LIMIT - 1));
    wdt_d   = (stall_o == 5'b00000 || wdt_hit) ? 16'd0 : wdt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdt_q <= 16'd0;
    else        wdt_q <= wdt_d;
  end

  assign stall_timeout_o = wdt_hit;
`else
  assign stall_timeout_o = 1'b0;
`endif

endmodule
